// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory line-fill arbiter.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_LINE_WORDS = 8;
    localparam int WORD_W         = 16;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Requester identifiers
    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker. On a tie it favours the port that was not
// granted last; last_grant only moves when the caller commits a grant.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_d,
    input  logic req_i,
    input  logic load,
    output logic any,
    output logic pick
);

    logic last_grant;

    // Combinational choice from the current requests and history
    always_comb begin
        any  = req_d | req_i;
        pick = PORT_D;
        if (req_d && req_i) begin
            pick = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (req_i) begin
            pick = PORT_I;
        end
    end

    // History register: reset to I so that D wins the first tie
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= PORT_I;
        end else if (load) begin
            last_grant <= pick;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Line-transfer arbiter between the D-cache and I-cache fill ports and a
// single-ported word-wide memory. One line = LINE_WORDS back-to-back accesses.
//
// Handshake: a port raises req and holds it; grant rises one cycle later and
// stays high for the whole line; wr and addr are captured at grant, so later
// changes (including dropping req) have no effect. done pulses for one cycle
// together with the final read response; grant falls on the following edge.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int LINE_WORDS = DEF_LINE_WORDS,
    localparam int IDX_W      = $clog2(LINE_WORDS),
    localparam int OFF_BITS   = IDX_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_W-1:0]     d_wdata,
    input  logic                  i_req,
    input  logic                  i_wr,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WORD_W-1:0]     i_wdata,
    output logic                  d_grant,
    output logic                  i_grant,
    output logic [IDX_W-1:0]      word_idx,
    output logic                  rsp_valid,
    output logic [IDX_W-1:0]      rsp_idx,
    output logic [WORD_W-1:0]     rsp_data,
    output logic                  d_done,
    output logic                  i_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_data_in,
    output logic                  mem_enable,
    output logic                  mem_wr,
    input  logic [WORD_W-1:0]     mem_data_out,
    output state_t                dbg_state
);

    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(LINE_WORDS - 1);

    state_t                         state;
    logic [IDX_W-1:0]               cnt;
    logic                           port_q;
    logic                           wr_q;
    logic [ADDR_WIDTH-OFF_BITS-1:0] base_q;

    logic arb_any;
    logic arb_pick;
    logic arb_load;

    // Byte-offset bits of the request address select nothing: lines are aligned
    logic unused_offset_bits;
    assign unused_offset_bits = &{1'b0, d_addr[OFF_BITS-1:0], i_addr[OFF_BITS-1:0]};

    assign arb_load  = (state == ST_IDLE) && arb_any;
    assign word_idx  = cnt;
    assign dbg_state = state;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_d (d_req),
        .req_i (i_req),
        .load  (arb_load),
        .any   (arb_any),
        .pick  (arb_pick)
    );

    // Memory side is driven straight from the latched transfer while BUSY
    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (state == ST_BUSY) begin
            mem_enable  = 1'b1;
            mem_wr      = wr_q;
            mem_addr    = {base_q, cnt, 1'b0};
            mem_data_in = (port_q == PORT_I) ? i_wdata : d_wdata;
        end
    end

    // Sequencer: grant in IDLE, one word per cycle in BUSY, completion in DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            port_q    <= PORT_D;
            wr_q      <= 1'b0;
            base_q    <= '0;
            d_grant   <= 1'b0;
            i_grant   <= 1'b0;
            d_done    <= 1'b0;
            i_done    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_idx   <= '0;
            rsp_data  <= '0;
        end else begin
            d_done    <= 1'b0;
            i_done    <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        port_q  <= arb_pick;
                        wr_q    <= (arb_pick == PORT_I) ? i_wr : d_wr;
                        base_q  <= (arb_pick == PORT_I) ? i_addr[ADDR_WIDTH-1:OFF_BITS]
                                                        : d_addr[ADDR_WIDTH-1:OFF_BITS];
                        d_grant <= (arb_pick == PORT_D);
                        i_grant <= (arb_pick == PORT_I);
                        cnt     <= '0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!wr_q) begin
                        rsp_valid <= 1'b1;
                        rsp_idx   <= cnt;
                        rsp_data  <= mem_data_out;
                    end
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        d_done <= (port_q == PORT_D);
                        i_done <= (port_q == PORT_I);
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    d_grant <= 1'b0;
                    i_grant <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference memory and arbitration
// history, expected accesses/responses/dones queued at stimulus time and
// consumed by an independent monitor.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW         = 16;
    localparam int LW         = 8;
    localparam int IW         = 3;
    localparam int LINE_BYTES = 2 * LW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          d_req = 1'b0, i_req = 1'b0;
    logic          d_wr = 1'b0, i_wr = 1'b0;
    logic [AW-1:0] d_addr = '0, i_addr = '0;
    logic [15:0]   d_wbase = '0, i_wbase = '0;
    logic [15:0]   d_wdata, i_wdata;
    logic          d_grant, i_grant, d_done, i_done;
    logic [IW-1:0] word_idx, rsp_idx;
    logic          rsp_valid;
    logic [15:0]   rsp_data;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data_in, mem_data_out;
    logic          mem_enable, mem_wr;
    state_t        dbg_state;

    // Requesters supply wdata for the word currently being issued
    assign d_wdata = d_wbase + 16'(word_idx);
    assign i_wdata = i_wbase + 16'(word_idx);

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .d_grant(d_grant), .i_grant(i_grant), .word_idx(word_idx),
        .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_data(rsp_data),
        .d_done(d_done), .i_done(i_done),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_data_out(mem_data_out),
        .dbg_state(dbg_state)
    );

    // ---------------- memory instance ----------------
    function automatic logic [15:0] init_val(input int w);
        if (w >= 8 && w < 16) return 16'hA000 + 16'(w - 8);
        return 16'(w * 40503) ^ 16'h3C5A;
    endfunction

    logic [15:0] mem [0:32767];
    logic        mem_ready = 1'b0;

    assign mem_data_out = mem[mem_addr[AW-1:1]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int w = 0; w < 32768; w++) mem[w] <= init_val(w);
            mem_ready <= 1'b1;
        end else if (mem_enable && mem_wr) begin
            mem[mem_addr[AW-1:1]] <= mem_data_in;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [15:0] ref_mem [0:32767];
    logic        rr_last;
    logic [32:0] exp_acc_q[$];   // {wr, addr, wdata}
    logic [18:0] exp_rsp_q[$];   // {idx, data}
    logic [0:0]  exp_done_q[$];  // port
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected effect of one line transfer (or its first nwords if cut short)
    task automatic push_xfer(input logic port, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wbase, input int nwords);
        logic [15:0] base;
        logic [15:0] a;
        base = addr & ~16'(LINE_BYTES - 1);
        for (int k = 0; k < nwords; k++) begin
            a = base + 16'(2 * k);
            if (wr) begin
                exp_acc_q.push_back({1'b1, a, wbase + 16'(k)});
                ref_mem[a[15:1]] = wbase + 16'(k);
            end else begin
                exp_acc_q.push_back({1'b0, a, 16'h0000});
                exp_rsp_q.push_back({3'(k), ref_mem[a[15:1]]});
            end
        end
        if (nwords == LW) exp_done_q.push_back(port);
        rr_last = port;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [32:0] ea;
        logic [18:0] er;
        logic [0:0]  ed;
        if (rst && mem_ready) begin
            chk("grant_excl", 32'(d_grant & i_grant), 0);
            chk("done_excl", 32'(d_done & i_done), 0);
            if (mem_enable) begin
                chk("addr_bit0", 32'(mem_addr[0]), 0);
                if (exp_acc_q.size() == 0) begin
                    chk("acc_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    ea = exp_acc_q.pop_front();
                    chk("acc_wr", 32'(mem_wr), 32'(ea[32]));
                    chk("acc_addr", 32'(mem_addr), 32'(ea[31:16]));
                    if (ea[32]) chk("acc_wdata", 32'(mem_data_in), 32'(ea[15:0]));
                end
            end
            if (rsp_valid) begin
                if (exp_rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
                end else begin
                    er = exp_rsp_q.pop_front();
                    chk("rsp_idx", 32'(rsp_idx), 32'(er[18:16]));
                    chk("rsp_data", 32'(rsp_data), 32'(er[15:0]));
                end
            end
            if (d_done || i_done) begin
                if (exp_done_q.size() == 0) begin
                    chk("done_unexpected", 32'({d_done, i_done}), 0);
                end else begin
                    ed = exp_done_q.pop_front();
                    chk("done_port", 32'(i_done), 32'(ed));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic sigv(input int w);
        case (w)
            0:       return d_grant;
            1:       return i_grant;
            2:       return d_done;
            default: return i_done;
        endcase
    endfunction

    task automatic wait_sig(input int w, input int limit, output int at);
        at = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (sigv(w)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk($sformatf("timeout_sig%0d", w), 0, 1);
    endtask

    task automatic drive(input logic port, input logic req, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wbase);
        if (port == PORT_D) begin
            d_req = req; d_wr = wr; d_addr = addr; d_wbase = wbase;
        end else begin
            i_req = req; i_wr = wr; i_addr = addr; i_wbase = wbase;
        end
    endtask

    task automatic set_req(input logic port, input logic req);
        if (port == PORT_D) d_req = req; else i_req = req;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rr_last = PORT_I;
    endtask

    // Single-port line transfer from IDLE; drop_after>0 releases req and
    // scrambles the address that many cycles into the transfer
    task automatic xfer(input logic port, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wbase, input int drop_after);
        int t0, tg, td;
        push_xfer(port, wr, addr, wbase, LW);
        @(negedge clk);
        t0 = cyc;
        drive(port, 1'b1, wr, addr, wbase);
        wait_sig(int'(port), 20, tg);
        chk("grant_latency", tg - t0, 1);
        if (drop_after > 0) begin
            repeat (drop_after) @(negedge clk);
            drive(port, 1'b0, wr, 16'hFFF0, wbase);
        end
        wait_sig(2 + int'(port), 20, td);
        chk("done_latency", td - t0, LW + 1);
        set_req(port, 1'b0);
        @(negedge clk);
        chk("grant_release", 32'({d_grant, i_grant}), 0);
    endtask

    // Both ports request together from IDLE; n line transfers in total
    task automatic pair(input logic dwr, input logic [15:0] daddr, input logic [15:0] dwb,
                        input logic iwr, input logic [15:0] iaddr, input logic [15:0] iwb,
                        input int n);
        logic first, p;
        int   rem [2];
        int   t0, tg, td;
        rem[0] = 0;
        rem[1] = 0;
        first = (rr_last == PORT_I) ? PORT_D : PORT_I;
        for (int j = 0; j < n; j++) begin
            p = first ^ 1'(j);
            push_xfer(p, p ? iwr : dwr, p ? iaddr : daddr, p ? iwb : dwb, LW);
            rem[int'(p)]++;
        end
        @(negedge clk);
        t0 = cyc;
        drive(PORT_D, 1'b1, dwr, daddr, dwb);
        drive(PORT_I, 1'b1, iwr, iaddr, iwb);
        for (int j = 0; j < n; j++) begin
            p = first ^ 1'(j);
            wait_sig(int'(p), 20, tg);
            chk($sformatf("pair_grant%0d_cycle", j), tg - t0, 1 + j * (LW + 2));
            wait_sig(2 + int'(p), 20, td);
            chk("pair_done_latency", td - tg, LW);
            rem[int'(p)]--;
            if (rem[int'(p)] == 0) set_req(p, 1'b0);
        end
        @(negedge clk);
        chk("pair_release", 32'({d_grant, i_grant}), 0);
    endtask

    // Reset lands in the 4th BUSY cycle of an I-port write
    task automatic reset_mid_write(input logic [15:0] addr, input logic [15:0] wbase);
        int t0, tg;
        push_xfer(PORT_I, 1'b1, addr, wbase, 4);
        @(negedge clk);
        t0 = cyc;
        drive(PORT_I, 1'b1, 1'b1, addr, wbase);
        wait_sig(1, 20, tg);
        chk("rmw_grant_latency", tg - t0, 1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        chk("rmw_mem_enable", 32'(mem_enable), 0);
        chk("rmw_grants", 32'({d_grant, i_grant}), 0);
        chk("rmw_dones", 32'({d_done, i_done}), 0);
        rst = 1'b1;
        rr_last = PORT_I;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic        p, w1, w2;
        logic [15:0] a1, a2;
        for (int w = 0; w < 32768; w++) ref_mem[w] = init_val(w);
        rr_last = PORT_I;

        repeat (3) @(negedge clk);
        chk("reset_grants", 32'({d_grant, i_grant}), 0);
        chk("reset_dones", 32'({d_done, i_done}), 0);
        chk("reset_rsp", 32'({rsp_valid, rsp_idx, rsp_data}), 0);
        chk("reset_mem", 32'({mem_enable, mem_wr}), 0);
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b1;

        // Read D line 0x0010 (preloaded 0xA000+k)
        xfer(PORT_D, 1'b0, 16'h0010, 16'h0000, 0);
        // Write I line 0x0120 then read it back
        xfer(PORT_I, 1'b1, 16'h0120, 16'h5500, 0);
        xfer(PORT_I, 1'b0, 16'h0120, 16'h0000, 0);
        // Simultaneous requests right after reset: D, I, D
        do_reset();
        pair(1'b0, 16'h0200, 16'h0000, 1'b0, 16'h0400, 16'h0000, 3);
        // Requester drops req and changes address mid-transfer
        xfer(PORT_D, 1'b0, 16'h0300, 16'h0000, 3);
        // Unaligned line address
        xfer(PORT_D, 1'b0, 16'h0017, 16'h0000, 0);
        // Reset in the middle of a write, then check which words landed
        reset_mid_write(16'h0520, 16'h7700);
        xfer(PORT_I, 1'b0, 16'h0520, 16'h0000, 0);

        // Randomized mix of single and contending transfers
        for (int r = 0; r < 16; r++) begin
            p  = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            w2 = 1'($urandom_range(0, 1));
            a1 = 16'($urandom_range(0, 16'h0FFF));
            a2 = ($urandom_range(0, 1) == 1) ? a1 : 16'($urandom_range(0, 16'h0FFF));
            if ($urandom_range(0, 2) == 0)
                xfer(p, w1, a1, 16'($urandom), 0);
            else
                pair(w1, a1, 16'($urandom), w2, a2, 16'($urandom), int'($urandom_range(2, 3)));
        end

        repeat (5) @(negedge clk);
        chk("acc_queue_empty", exp_acc_q.size(), 0);
        chk("rsp_queue_empty", exp_rsp_q.size(), 0);
        chk("done_queue_empty", exp_done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
